// File: rtl/exc_request_ctrl.sv
// -----------------------------------------------------------------------------
// exc_request_ctrl
//
// Exception request controller: the source side of the Exc/ExcAck/ERet/EStatus
// handshake with the processor's exception unit. It latches single-cycle
// events from NSRC sources into pending flags and arbitrates them by fixed
// priority (lowest index wins, timer last). It presents one request at a time
// with a frozen 4-bit cause code. After the exception unit acknowledges, no
// further request is raised until the handler retires with ERet.
//
// Optional feature: define EXC_TIMER_EN to enable a periodic timer source.
// The timer presents cause code 4'hF. When the macro is undefined,
// tmr_period is ignored.
//
// Parameters:
//   NSRC     number of event sources (1..14); source i reports code i+1
//   TIMER_W  width of the timer counter and period
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-low reset
//   src_req     per-source event pulses
//   ExcAck      exception unit acknowledge (vector reached fetch)
//   ERet        ERET retiring, ends the handler
//   tmr_period  timer period in cycles, 0 stops the timer
//   Exc         exception request (registered)
//   EStatus     cause code of the presented request (registered)
//   pending     pending flags per source
//   in_handler  high while the handler runs
//   src_ovf     sticky per-source overflow (event while already pending)
// -----------------------------------------------------------------------------
module exc_request_ctrl #(
    parameter int unsigned NSRC    = 4,
    parameter int unsigned TIMER_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NSRC-1:0]    src_req,
    input  logic               ExcAck,
    input  logic               ERet,
    input  logic [TIMER_W-1:0] tmr_period,
    output logic               Exc,
    output logic [3:0]         EStatus,
    output logic [NSRC-1:0]    pending,
    output logic               in_handler,
    output logic [NSRC-1:0]    src_ovf
);

    localparam int unsigned CODE_W = 4;

    localparam logic [CODE_W-1:0] CODE_NONE = 4'h0;
    localparam logic [CODE_W-1:0] CODE_TMR  = 4'hF;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_HANDLER = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              exc_q, exc_d;
    logic [CODE_W-1:0] estatus_q, estatus_d;
    logic              in_handler_q, in_handler_d;
    logic [NSRC-1:0]   pending_q, pending_d;
    logic [NSRC-1:0]   src_ovf_q, src_ovf_d;

    logic              ack_fire_c;
    logic [NSRC-1:0]   src_clr_c;
    logic              tmr_clr_c;
    logic              tmr_pend_c;
    logic              any_pend_c;
    logic [CODE_W-1:0] win_code_c;

    // Acknowledge is only meaningful while a request is presented.
    assign ack_fire_c = (state_q == S_REQ) && ExcAck;

    // Fixed-priority winner: walk from the highest index down so the lowest
    // pending index is assigned last and wins; the timer is the fallback.
    always_comb begin
        win_code_c = tmr_pend_c ? CODE_TMR : CODE_NONE;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                win_code_c = CODE_W'(i + 1);
            end
        end
    end

    assign any_pend_c = (|pending_q) | tmr_pend_c;

    // The flag to clear on ack is the one whose code is frozen in EStatus.
    always_comb begin
        src_clr_c = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            src_clr_c[i] = ack_fire_c && (estatus_q == CODE_W'(i + 1));
        end
        tmr_clr_c = ack_fire_c && (estatus_q == CODE_TMR);
    end

    // Pending accumulation; a new event in the clearing cycle keeps the flag.
    always_comb begin
        pending_d = (pending_q & ~src_clr_c) | src_req;
        src_ovf_d = src_ovf_q | (src_req & pending_q & ~src_clr_c);
    end

`ifdef EXC_TIMER_EN
    logic [TIMER_W-1:0] tmr_cnt_q, tmr_cnt_d;
    logic               tmr_pend_q, tmr_pend_d;
    logic               tmr_wrap_c;

    // Free-running period counter. It wraps when it reaches period-1. The >=
    // also recovers a count left above a newly shortened period.
    always_comb begin
        tmr_cnt_d  = tmr_cnt_q;
        tmr_wrap_c = 1'b0;
        if (tmr_period == '0) begin
            tmr_cnt_d = '0;
        end else if (tmr_cnt_q >= (tmr_period - TIMER_W'(1))) begin
            tmr_cnt_d  = '0;
            tmr_wrap_c = 1'b1;
        end else begin
            tmr_cnt_d = tmr_cnt_q + TIMER_W'(1);
        end
        tmr_pend_d = (tmr_pend_q & ~tmr_clr_c) | tmr_wrap_c;
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr_cnt_q  <= '0;
            tmr_pend_q <= 1'b0;
        end else begin
            tmr_cnt_q  <= tmr_cnt_d;
            tmr_pend_q <= tmr_pend_d;
        end
    end

    assign tmr_pend_c = tmr_pend_q;
`else
    logic unused_tmr_c;

    assign tmr_pend_c   = 1'b0;
    assign unused_tmr_c = ^{tmr_period, tmr_clr_c};
`endif

    // Request FSM: next state plus the registered output values.
    always_comb begin
        state_d   = state_q;
        estatus_d = estatus_q;
        case (state_q)
            S_IDLE: begin
                if (any_pend_c) begin
                    state_d   = S_REQ;
                    estatus_d = win_code_c;
                end
            end
            S_REQ: begin
                // EStatus stays frozen even if a higher-priority source arrives.
                if (ExcAck) begin
                    state_d = S_HANDLER;
                end
            end
            S_HANDLER: begin
                if (ERet) begin
                    state_d   = S_IDLE;
                    estatus_d = CODE_NONE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                estatus_d = CODE_NONE;
            end
        endcase
        exc_d        = (state_d == S_REQ);
        in_handler_d = (state_d == S_HANDLER);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            exc_q        <= 1'b0;
            estatus_q    <= CODE_NONE;
            in_handler_q <= 1'b0;
            pending_q    <= '0;
            src_ovf_q    <= '0;
        end else begin
            state_q      <= state_d;
            exc_q        <= exc_d;
            estatus_q    <= estatus_d;
            in_handler_q <= in_handler_d;
            pending_q    <= pending_d;
            src_ovf_q    <= src_ovf_d;
        end
    end

    assign Exc        = exc_q;
    assign EStatus    = estatus_q;
    assign pending    = pending_q;
    assign in_handler = in_handler_q;
    assign src_ovf    = src_ovf_q;

endmodule

// File: tb/tb_exc_request_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exc_request_ctrl
//
// Self-checking bench for exc_request_ctrl (NSRC=4, TIMER_W=16).
// A table holds per-cycle inputs and the outputs expected during that cycle.
// Hand-written sequences follow for reset during a request and the timer.
// -----------------------------------------------------------------------------
module tb_exc_request_ctrl;

    localparam int unsigned NSRC    = 4;
    localparam int unsigned TIMER_W = 16;

    logic               clk;
    logic               reset;
    logic [NSRC-1:0]    src_req;
    logic               ExcAck;
    logic               ERet;
    logic [TIMER_W-1:0] tmr_period;
    logic               Exc;
    logic [3:0]         EStatus;
    logic [NSRC-1:0]    pending;
    logic               in_handler;
    logic [NSRC-1:0]    src_ovf;

    exc_request_ctrl #(.NSRC(NSRC), .TIMER_W(TIMER_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .src_req    (src_req),
        .ExcAck     (ExcAck),
        .ERet       (ERet),
        .tmr_period (tmr_period),
        .Exc        (Exc),
        .EStatus    (EStatus),
        .pending    (pending),
        .in_handler (in_handler),
        .src_ovf    (src_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] src;
        logic       ack;
        logic       eret;
        logic       exc;
        logic [3:0] es;
        logic [3:0] pend;
        logic       ih;
        logic [3:0] ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] s, input logic a, input logic r, input logic x,
                       input logic [3:0] e, input logic [3:0] p, input logic h,
                       input logic [3:0] o);
        vec_t v;
        v.src = s; v.ack = a; v.eret = r;
        v.exc = x; v.es = e; v.pend = p; v.ih = h; v.ovf = o;
        vecs.push_back(v);
    endtask

    function automatic logic [13:0] pack_out();
        return {Exc, EStatus, pending, in_handler, src_ovf};
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        src_req = '0;
        ExcAck = 1'b0;
        ERet = 1'b0;
        tmr_period = '0;

        //    src      ack  eret  Exc  ES     pend     ih   ovf
        // single event
        add(4'b0100, 0, 0, 0, 4'h0, 4'b0000, 0, 4'b0000); // 0
        add(4'b0000, 0, 0, 0, 4'h0, 4'b0100, 0, 4'b0000); // 1
        add(4'b0000, 1, 0, 1, 4'h3, 4'b0100, 0, 4'b0000); // 2
        add(4'b0000, 0, 1, 0, 4'h3, 4'b0000, 1, 4'b0000); // 3
        add(4'b0000, 0, 0, 0, 4'h0, 4'b0000, 0, 4'b0000); // 4
        // priority and freeze
        add(4'b1010, 0, 0, 0, 4'h0, 4'b0000, 0, 4'b0000); // 5
        add(4'b0000, 0, 0, 0, 4'h0, 4'b1010, 0, 4'b0000); // 6
        add(4'b0001, 0, 0, 1, 4'h2, 4'b1010, 0, 4'b0000); // 7
        add(4'b0000, 1, 0, 1, 4'h2, 4'b1011, 0, 4'b0000); // 8
        add(4'b0000, 0, 1, 0, 4'h2, 4'b1001, 1, 4'b0000); // 9
        add(4'b0000, 0, 0, 0, 4'h0, 4'b1001, 0, 4'b0000); // 10
        add(4'b0000, 1, 0, 1, 4'h1, 4'b1001, 0, 4'b0000); // 11
        add(4'b0000, 0, 1, 0, 4'h1, 4'b1000, 1, 4'b0000); // 12
        add(4'b0000, 0, 0, 0, 4'h0, 4'b1000, 0, 4'b0000); // 13
        add(4'b0000, 1, 0, 1, 4'h4, 4'b1000, 0, 4'b0000); // 14
        add(4'b0000, 0, 1, 0, 4'h4, 4'b0000, 1, 4'b0000); // 15
        add(4'b0000, 0, 0, 0, 4'h0, 4'b0000, 0, 4'b0000); // 16
        // overflow and set/clear collision
        add(4'b0100, 0, 0, 0, 4'h0, 4'b0000, 0, 4'b0000); // 17
        add(4'b0100, 0, 0, 0, 4'h0, 4'b0100, 0, 4'b0000); // 18
        add(4'b0100, 1, 0, 1, 4'h3, 4'b0100, 0, 4'b0100); // 19
        add(4'b0000, 0, 1, 0, 4'h3, 4'b0100, 1, 4'b0100); // 20
        add(4'b0000, 0, 0, 0, 4'h0, 4'b0100, 0, 4'b0100); // 21
        add(4'b0000, 1, 0, 1, 4'h3, 4'b0100, 0, 4'b0100); // 22
        // handler masking, ERet at 26 -> Exc at 28
        add(4'b0001, 0, 0, 0, 4'h3, 4'b0000, 1, 4'b0100); // 23
        add(4'b0010, 0, 0, 0, 4'h3, 4'b0001, 1, 4'b0100); // 24
        add(4'b1000, 0, 0, 0, 4'h3, 4'b0011, 1, 4'b0100); // 25
        add(4'b0000, 0, 1, 0, 4'h3, 4'b1011, 1, 4'b0100); // 26
        add(4'b0000, 0, 0, 0, 4'h0, 4'b1011, 0, 4'b0100); // 27
        add(4'b0000, 1, 0, 1, 4'h1, 4'b1011, 0, 4'b0100); // 28
        add(4'b0000, 0, 1, 0, 4'h1, 4'b1010, 1, 4'b0100); // 29
        add(4'b0000, 0, 0, 0, 4'h0, 4'b1010, 0, 4'b0100); // 30
        add(4'b0000, 1, 0, 1, 4'h2, 4'b1010, 0, 4'b0100); // 31
        add(4'b0000, 0, 1, 0, 4'h2, 4'b1000, 1, 4'b0100); // 32
        add(4'b0000, 0, 0, 0, 4'h0, 4'b1000, 0, 4'b0100); // 33
        add(4'b0000, 1, 0, 1, 4'h4, 4'b1000, 0, 4'b0100); // 34
        add(4'b0000, 0, 1, 0, 4'h4, 4'b0000, 1, 4'b0100); // 35
        add(4'b0000, 0, 0, 0, 4'h0, 4'b0000, 0, 4'b0100); // 36

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(pack_out()), 32'd0);
        reset = 1'b1;

        // table: check outputs of this cycle, then drive this cycle's inputs
        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            chk($sformatf("vec%0d {Exc,ES,pend,ih,ovf}", k), 32'(pack_out()),
                32'({vecs[k].exc, vecs[k].es, vecs[k].pend, vecs[k].ih, vecs[k].ovf}));
            src_req = vecs[k].src;
            ExcAck  = vecs[k].ack;
            ERet    = vecs[k].eret;
        end
        @(negedge clk);
        src_req = '0; ExcAck = 1'b0; ERet = 1'b0;

        // reset asserted mid-request clears everything asynchronously
        src_req = 4'b0010;
        @(negedge clk);
        src_req = '0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_exc", 32'(Exc), 32'd1);
        chk("pre_reset_es", 32'(EStatus), 32'h2);
        #2 reset = 1'b0;
        #1 chk("async_reset_out", 32'(pack_out()), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("post_reset%0d {Exc,pend}", c), 32'({Exc, pending}), 32'd0);
        end

`ifdef EXC_TIMER_EN
        begin : timer_on
            int last;
            int rises;
            int seen;
            logic prev;
            last = -1; rises = 0; prev = 1'b0;
            tmr_period = 16'd5;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                ExcAck = Exc;
                ERet   = in_handler;
                if (Exc && !prev) begin
                    chk($sformatf("tmr_code%0d", c), 32'(EStatus), 32'hF);
                    if (last >= 0) chk($sformatf("tmr_interval%0d", c), 32'(c - last), 32'd5);
                    last = c;
                    rises++;
                end
                prev = Exc;
            end
            chk("tmr_rise_count_ge10", 32'(rises >= 10), 32'd1);
            tmr_period = '0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                ExcAck = Exc;
                ERet   = in_handler;
            end
            seen = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                ExcAck = Exc;
                ERet   = in_handler;
                if (Exc) seen++;
            end
            chk("tmr_stopped_no_exc", 32'(seen), 32'd0);
        end
`else
        begin : timer_off
            int seen_exc;
            int seen_f;
            seen_exc = 0; seen_f = 0;
            tmr_period = 16'd5;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                ExcAck = Exc;
                ERet   = in_handler;
                if (Exc) seen_exc++;
                if (EStatus == 4'hF) seen_f++;
            end
            chk("no_timer_exc", 32'(seen_exc), 32'd0);
            chk("no_code_f", 32'(seen_f), 32'd0);
        end
`endif
        ExcAck = 1'b0;
        ERet = 1'b0;
        tmr_period = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
